// File: rtl/snake_dir_pkg.sv
// Shared direction encodings for the snake direction path.
// Directions are one-hot: bit0 right, bit1 up, bit2 down, bit3 left.
package snake_dir_pkg;

  localparam logic [3:0] DIR_RIGHT = 4'b0001;
  localparam logic [3:0] DIR_UP    = 4'b0010;
  localparam logic [3:0] DIR_DOWN  = 4'b0100;
  localparam logic [3:0] DIR_LEFT  = 4'b1000;

  // The encoding places opposite pairs at mirrored bit positions, so a bit reverse flips direction
  function automatic logic [3:0] dir_opposite(input logic [3:0] d);
    return {d[0], d[1], d[2], d[3]};
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// One push-button: 2-FF synchroniser, stability counter and a single-cycle press pulse.
// The internal stable level is active-high (1 = pressed).
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_key_n,
  output logic o_press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;
  logic          w_pressed_sync;

  assign w_pressed_sync = ~r_sync2;
  assign o_press        = r_press;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (w_pressed_sync != r_stable) begin
        // This is the DEBOUNCE_CYCLES-th consecutive differing cycle
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= w_pressed_sync;
          r_cnt    <= '0;
          r_press  <= w_pressed_sync;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/dir_input_queue.sv
// Turns four debounced active-low buttons into a queued one-hot direction, one turn per game tick.
// Define DIR_REVERSE_FILTER_EN to also reject turns opposite to the reference direction.
module dir_input_queue
  import snake_dir_pkg::*;
#(
  parameter int         DEPTH           = 4,
  parameter int         DEBOUNCE_CYCLES = 500000,
  parameter logic [3:0] DEFAULT_DIR     = 4'b0001
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [3:0]                   key_n,
  input  logic                         game_tick,
  input  logic                         flush,
  output logic [3:0]                   dir_out,
  output logic [$clog2(DEPTH+1)-1:0]   queue_count,
  output logic                         drop_pulse
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [3:0]    w_press;
  logic [3:0]    w_evt;
  logic [3:0]    w_ref;
  logic          w_any;
  logic          w_multi;
  logic          w_full;
  logic          w_opp;
  logic          w_reject;
  logic          w_push;
  logic          w_pop;

  logic [3:0]    r_mem [DEPTH];
  logic [3:0]    r_tail;
  logic [3:0]    r_dir;
  logic [PW-1:0] r_rd;
  logic [PW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk     (clk),
      .reset_n (reset_n),
      .i_key_n (key_n[g]),
      .o_press (w_press[g])
    );
  end

  always_comb begin
    // Isolate the lowest set bit so simultaneous presses resolve to the lowest index
    w_evt   = w_press & (~w_press + 4'd1);
    w_any   = |w_press;
    w_multi = |(w_press & ~w_evt);
    w_ref   = (r_count != '0) ? r_tail : r_dir;
    w_full  = (r_count == CW'(DEPTH));
`ifdef DIR_REVERSE_FILTER_EN
    w_opp   = (w_evt == dir_opposite(w_ref));
`else
    w_opp   = 1'b0;
`endif
    w_reject = (w_evt == w_ref) | w_opp | w_full;
    w_push   = w_any & ~w_reject & ~flush;
    w_pop    = game_tick & (r_count != '0) & ~flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_dir   <= DEFAULT_DIR;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else if (flush) begin
      r_dir   <= DEFAULT_DIR;
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= w_any & (w_multi | w_reject);
      if (w_pop) begin
        r_dir <= r_mem[r_rd];
        r_rd  <= ptr_inc(r_rd);
      end
      if (w_push) begin
        r_wr <= ptr_inc(r_wr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset: it is only read while the count says it holds data
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_evt;
      r_tail      <= w_evt;
    end
  end

  assign dir_out     = r_dir;
  assign queue_count = r_count;
  assign drop_pulse  = r_drop;

endmodule
